// File: rtl/bp_repair_sched_pkg.sv
// Shared constants and FSM encoding for the branch-predictor repair scheduler.
package bp_repair_sched_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned RA_W_DEF   = 4;
  localparam int unsigned CP_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  // Scheduler state: idle, or presenting a repair on the update port.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/bp_repair_sched_repair_fifo.sv
// Synchronous FIFO holding back-end repair requests; clear empties it in one cycle.
module repair_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Wrap bit differs with equal index => full; identical pointers => empty.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count_c = wr_ptr - rd_ptr;
  assign rdata_c = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);

  // Pointer update; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until pointed to, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bp_repair_sched.sv
// Branch-predictor repair scheduler: one-entry SBA slot, BSC FIFO, registered issue port.
module bp_repair_sched
  import bp_repair_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RA_W   = RA_W_DEF,
  parameter int unsigned CP_W   = CP_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sba_flush_i,
  input  logic [ADDR_W-1:0] sba_vaddr_i,
  input  logic [ADDR_W-1:0] sba_dest_i,
  input  logic              sba_take_i,
  input  logic [CP_W-1:0]   sba_cp_i,
  input  logic [RA_W-1:0]   sba_ra_i,
  input  logic              bsc_diff_i,
  input  logic [ADDR_W-1:0] bsc_vaddr_i,
  input  logic [ADDR_W-1:0] bsc_dest_i,
  input  logic              bsc_take_i,
  input  logic [CP_W-1:0]   bsc_cp_i,
  input  logic [RA_W-1:0]   bsc_ra_i,
  output logic              rep_valid_o,
  input  logic              rep_ready_i,
  output logic [ADDR_W-1:0] rep_vaddr_o,
  output logic [ADDR_W-1:0] rep_dest_o,
  output logic              rep_take_o,
  output logic [CP_W-1:0]   rep_cp_o,
  output logic [RA_W-1:0]   rep_ra_o,
  output logic              rep_src_o,
  output logic [CNT_W-1:0]  sba_drop_cnt_o,
  output logic [CNT_W-1:0]  bsc_drop_cnt_o
);

  localparam int unsigned REQ_W = RA_W + CP_W + 1 + 2 * ADDR_W;
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned INC_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  // Packed repair request {ra, cp, take, dest, vaddr}.
  typedef struct packed {
    logic [RA_W-1:0]   ra;
    logic [CP_W-1:0]   cp;
    logic              take;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] vaddr;
  } req_t;

  state_e           state_q;
  state_e           state_d;
  req_t             sba_req;
  req_t             bsc_req;
  req_t             slot_q;
  logic             slot_valid_q;
  req_t             fifo_head;
  req_t             out_d;
  logic [REQ_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W-1:0] fifo_count;
  logic             fifo_push;
  logic             any_pending;
  logic             load;
  logic             take_slot;
  logic             pop_fifo;
  logic [INC_W-1:0] bsc_inc;
  logic             sba_drop;
  logic [SUM_W-1:0] bsc_sum;
  logic [SUM_W-1:0] sba_sum;

  assign sba_req = '{ra: sba_ra_i, cp: sba_cp_i, take: sba_take_i,
                     dest: sba_dest_i, vaddr: sba_vaddr_i};
  assign bsc_req = '{ra: bsc_ra_i, cp: bsc_cp_i, take: bsc_take_i,
                     dest: bsc_dest_i, vaddr: bsc_vaddr_i};

  // An SBA flush squashes the FIFO, so a same-cycle BSC request never enters it.
  assign fifo_push = bsc_diff_i && !sba_flush_i;

  repair_fifo #(
    .W     (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .pop     (pop_fifo),
    .clear   (sba_flush_i),
    .wdata   (REQ_W'(bsc_req)),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count_c (fifo_count)
  );

  assign fifo_head   = req_t'(fifo_rdata);
  assign any_pending = slot_valid_q || !fifo_empty;
  assign out_d       = slot_valid_q ? slot_q : fifo_head;
  assign take_slot   = load && slot_valid_q;
  assign pop_fifo    = load && !slot_valid_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and load decision; a handshake may reload the next winner in the same cycle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_pending) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rep_ready_i) begin
          if (any_pending) load    = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Drop accounting: squash discards what is left in the FIFO after this cycle's pop, plus the new request.
  always_comb begin
    bsc_inc  = '0;
    sba_drop = sba_flush_i && slot_valid_q && !take_slot;
    if (sba_flush_i) begin
      bsc_inc = INC_W'(fifo_count) - INC_W'(pop_fifo) + INC_W'(bsc_diff_i);
    end else if (bsc_diff_i && fifo_full && !pop_fifo) begin
      bsc_inc = INC_W'(1);
    end
    bsc_sum = SUM_W'(bsc_drop_cnt_o) + SUM_W'(bsc_inc);
    sba_sum = SUM_W'(sba_drop_cnt_o) + SUM_W'(sba_drop);
  end

  // SBA slot: a new flush always lands here, overwriting any unissued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
    end else if (sba_flush_i) begin
      slot_valid_q <= 1'b1;
      slot_q       <= sba_req;
    end else if (take_slot) begin
      slot_valid_q <= 1'b0;
    end
  end

  // Output register: payload only changes on a load, so it is stable while waiting for ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_valid_o <= 1'b0;
      rep_src_o   <= 1'b0;
      rep_vaddr_o <= '0;
      rep_dest_o  <= '0;
      rep_take_o  <= 1'b0;
      rep_cp_o    <= '0;
      rep_ra_o    <= '0;
    end else if (load) begin
      rep_valid_o <= 1'b1;
      rep_src_o   <= slot_valid_q;
      rep_vaddr_o <= out_d.vaddr;
      rep_dest_o  <= out_d.dest;
      rep_take_o  <= out_d.take;
      rep_cp_o    <= out_d.cp;
      rep_ra_o    <= out_d.ra;
    end else if (state_d == ST_IDLE) begin
      rep_valid_o <= 1'b0;
    end
  end

  // Saturating drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sba_drop_cnt_o <= '0;
      bsc_drop_cnt_o <= '0;
    end else begin
      sba_drop_cnt_o <= sba_sum[CNT_W] ? '1 : sba_sum[CNT_W-1:0];
      bsc_drop_cnt_o <= bsc_sum[CNT_W] ? '1 : bsc_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_bp_repair_sched.sv
// Scoreboard bench for bp_repair_sched: directed stimulus, monitor checks every handshake.
module tb_bp_repair_sched;

  logic        clk;
  logic        rst_n;
  logic        sba_flush_i;
  logic [31:0] sba_vaddr_i;
  logic [31:0] sba_dest_i;
  logic        sba_take_i;
  logic [31:0] sba_cp_i;
  logic [3:0]  sba_ra_i;
  logic        bsc_diff_i;
  logic [31:0] bsc_vaddr_i;
  logic [31:0] bsc_dest_i;
  logic        bsc_take_i;
  logic [31:0] bsc_cp_i;
  logic [3:0]  bsc_ra_i;
  logic        rep_valid_o;
  logic        rep_ready_i;
  logic [31:0] rep_vaddr_o;
  logic [31:0] rep_dest_o;
  logic        rep_take_o;
  logic [31:0] rep_cp_o;
  logic [3:0]  rep_ra_o;
  logic        rep_src_o;
  logic [15:0] sba_drop_cnt_o;
  logic [15:0] bsc_drop_cnt_o;

  typedef struct packed {
    logic        src;
    logic [31:0] vaddr;
    logic [31:0] dest;
    logic        take;
    logic [31:0] cp;
    logic [3:0]  ra;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp;
  exp_t mon_got;
  int   tests = 0;
  int   fails = 0;

  bp_repair_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sba_flush_i    (sba_flush_i),
    .sba_vaddr_i    (sba_vaddr_i),
    .sba_dest_i     (sba_dest_i),
    .sba_take_i     (sba_take_i),
    .sba_cp_i       (sba_cp_i),
    .sba_ra_i       (sba_ra_i),
    .bsc_diff_i     (bsc_diff_i),
    .bsc_vaddr_i    (bsc_vaddr_i),
    .bsc_dest_i     (bsc_dest_i),
    .bsc_take_i     (bsc_take_i),
    .bsc_cp_i       (bsc_cp_i),
    .bsc_ra_i       (bsc_ra_i),
    .rep_valid_o    (rep_valid_o),
    .rep_ready_i    (rep_ready_i),
    .rep_vaddr_o    (rep_vaddr_o),
    .rep_dest_o     (rep_dest_o),
    .rep_take_o     (rep_take_o),
    .rep_cp_o       (rep_cp_o),
    .rep_ra_o       (rep_ra_o),
    .rep_src_o      (rep_src_o),
    .sba_drop_cnt_o (sba_drop_cnt_o),
    .bsc_drop_cnt_o (bsc_drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload derived from a request id so every request is distinguishable.
  function automatic exp_t mk(input logic src, input logic [31:0] id);
    exp_t e;
    e.src   = src;
    e.vaddr = 32'h1000_0000 | id;
    e.dest  = 32'h2000_0000 | id;
    e.take  = id[0];
    e.cp    = 32'hC000_0000 | id;
    e.ra    = id[3:0];
    return e;
  endfunction

  // Monitor: every accepted repair must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rep_valid_o && rep_ready_i) begin
      mon_got.src   = rep_src_o;
      mon_got.vaddr = rep_vaddr_o;
      mon_got.dest  = rep_dest_o;
      mon_got.take  = rep_take_o;
      mon_got.cp    = rep_cp_o;
      mon_got.ra    = rep_ra_o;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_repair: got src=%0d vaddr=%h, required no repair",
                 mon_got.src, mon_got.vaddr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got != mon_exp) begin
          fails++;
          $display("FAIL repair_payload: got %h, required %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sba(input logic [31:0] id);
    exp_t e;
    e           = mk(1'b1, id);
    sba_flush_i = 1'b1;
    sba_vaddr_i = e.vaddr;
    sba_dest_i  = e.dest;
    sba_take_i  = e.take;
    sba_cp_i    = e.cp;
    sba_ra_i    = e.ra;
  endtask

  task automatic drive_bsc(input logic [31:0] id);
    exp_t e;
    e           = mk(1'b0, id);
    bsc_diff_i  = 1'b1;
    bsc_vaddr_i = e.vaddr;
    bsc_dest_i  = e.dest;
    bsc_take_i  = e.take;
    bsc_cp_i    = e.cp;
    bsc_ra_i    = e.ra;
  endtask

  task automatic idle_inputs();
    sba_flush_i = 1'b0;
    bsc_diff_i  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    rep_ready_i = 1'b0;
    idle_inputs();
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait, bounded, until the scoreboard has been fully consumed.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    sba_vaddr_i = '0; sba_dest_i = '0; sba_take_i = 1'b0; sba_cp_i = '0; sba_ra_i = '0;
    bsc_vaddr_i = '0; bsc_dest_i = '0; bsc_take_i = 1'b0; bsc_cp_i = '0; bsc_ra_i = '0;
    apply_reset();

    // Reset state
    check("reset_valid", 64'(rep_valid_o), 64'd0);
    check("reset_src", 64'(rep_src_o), 64'd0);
    check("reset_vaddr", 64'(rep_vaddr_o), 64'd0);
    check("reset_sba_cnt", 64'(sba_drop_cnt_o), 64'd0);
    check("reset_bsc_cnt", 64'(bsc_drop_cnt_o), 64'd0);

    // 1: single SBA, ready high
    apply_reset();
    rep_ready_i = 1'b1;
    exp_q.push_back(mk(1'b1, 32'h11));
    drive_sba(32'h11);
    tick();
    idle_inputs();
    check("t1_not_yet_valid", 64'(rep_valid_o), 64'd0);
    tick();
    check("t1_valid", 64'(rep_valid_o), 64'd1);
    check("t1_src", 64'(rep_src_o), 64'd1);
    tick();
    check("t1_back_idle", 64'(rep_valid_o), 64'd0);
    check("t1_scoreboard", 64'(exp_q.size()), 64'd0);

    // 2: BSC burst with ready low; one in the output reg, four fill the FIFO, the sixth drops
    apply_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, 32'(20 + i)));
    for (int i = 0; i < 6; i++) begin
      drive_bsc(32'(20 + i));
      tick();
    end
    idle_inputs();
    check("t2_bsc_drop", 64'(bsc_drop_cnt_o), 64'd1);
    check("t2_head_valid", 64'(rep_valid_o), 64'd1);
    check("t2_head_vaddr", 64'(rep_vaddr_o), 64'h1000_0014);
    rep_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_back_to_back", 64'(rep_valid_o), 64'd1);
    end
    tick();
    check("t2_done_idle", 64'(rep_valid_o), 64'd0);
    check("t2_scoreboard", 64'(exp_q.size()), 64'd0);
    rep_ready_i = 1'b0;

    // 3: SBA and BSC in the same cycle
    apply_reset();
    rep_ready_i = 1'b1;
    exp_q.push_back(mk(1'b1, 32'h30));
    drive_sba(32'h30);
    drive_bsc(32'h31);
    tick();
    idle_inputs();
    check("t3_bsc_drop", 64'(bsc_drop_cnt_o), 64'd1);
    drain("t3_drain");
    tick();
    tick();
    check("t3_fifo_empty", 64'(rep_valid_o), 64'd0);
    check("t3_sba_drop", 64'(sba_drop_cnt_o), 64'd0);

    // 4: squash leaves the presented BSC alone
    apply_reset();
    exp_q.push_back(mk(1'b0, 32'h40));
    exp_q.push_back(mk(1'b1, 32'h50));
    drive_bsc(32'h40); tick();
    drive_bsc(32'h41); tick();
    drive_bsc(32'h42); tick();
    idle_inputs();
    check("t4_bsc0_valid", 64'(rep_valid_o), 64'd1);
    check("t4_bsc0_vaddr", 64'(rep_vaddr_o), 64'h1000_0040);
    drive_sba(32'h50);
    tick();
    idle_inputs();
    check("t4_squash_cnt", 64'(bsc_drop_cnt_o), 64'd2);
    tick();
    tick();
    check("t4_stable_valid", 64'(rep_valid_o), 64'd1);
    check("t4_stable_vaddr", 64'(rep_vaddr_o), 64'h1000_0040);
    check("t4_stable_src", 64'(rep_src_o), 64'd0);
    rep_ready_i = 1'b1;
    drain("t4_drain");
    tick();
    tick();
    check("t4_idle", 64'(rep_valid_o), 64'd0);

    // 5: back-to-back SBA, then an overwrite of the occupied slot
    apply_reset();
    exp_q.push_back(mk(1'b1, 32'h60));
    exp_q.push_back(mk(1'b1, 32'h61));
    drive_sba(32'h60); tick();
    drive_sba(32'h61); tick();
    idle_inputs();
    check("t5_first_vaddr", 64'(rep_vaddr_o), 64'h1000_0060);
    check("t5_first_src", 64'(rep_src_o), 64'd1);
    check("t5_no_drop", 64'(sba_drop_cnt_o), 64'd0);
    tick();
    rep_ready_i = 1'b1;
    drain("t5_drain_a");
    rep_ready_i = 1'b0;
    tick();
    exp_q.push_back(mk(1'b1, 32'h70));
    exp_q.push_back(mk(1'b1, 32'h72));
    drive_sba(32'h70); tick();
    drive_sba(32'h71); tick();
    drive_sba(32'h72); tick();
    idle_inputs();
    check("t5_overwrite_drop", 64'(sba_drop_cnt_o), 64'd1);
    check("t5_presented_vaddr", 64'(rep_vaddr_o), 64'h1000_0070);
    rep_ready_i = 1'b1;
    drain("t5_drain_b");
    tick();
    tick();
    check("t5_idle", 64'(rep_valid_o), 64'd0);

    // 6: reset mid-issue with the FIFO non-empty
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_bsc(32'(90 + i));
      tick();
    end
    idle_inputs();
    check("t6_pre_valid", 64'(rep_valid_o), 64'd1);
    check("t6_pre_drop", 64'(bsc_drop_cnt_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(rep_valid_o), 64'd0);
    check("t6_async_bsc_cnt", 64'(bsc_drop_cnt_o), 64'd0);
    check("t6_async_sba_cnt", 64'(sba_drop_cnt_o), 64'd0);
    tick();
    rst_n = 1'b1;
    rep_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_fifo_cleared", 64'(rep_valid_o), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
